// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache and D-cache for the single physical-memory port.
// Grants one whole-line transfer at a time, alternating on ties, with per-port transfer counters.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,

    input  logic         icache_read,
    input  logic [15:0]  icache_address,
    output logic [127:0] icache_rdata,
    output logic         icache_resp,

    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [15:0]  dcache_address,
    input  logic [127:0] dcache_wdata,
    output logic [127:0] dcache_rdata,
    output logic         dcache_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,

    output logic [15:0]  icache_xfers,
    output logic [15:0]  dcache_xfers
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t      state, state_next;
    port_t       last_grant, last_grant_next;
    logic [15:0] icache_cnt, icache_cnt_next;
    logic [15:0] dcache_cnt, dcache_cnt_next;
    logic        req_i, req_d;

    assign req_i = icache_read;
    assign req_d = dcache_read | dcache_write;

    assign icache_xfers = icache_cnt;
    assign dcache_xfers = dcache_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_I;
            icache_cnt <= 16'h0000;
            dcache_cnt <= 16'h0000;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            icache_cnt <= icache_cnt_next;
            dcache_cnt <= dcache_cnt_next;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        icache_cnt_next = icache_cnt;
        dcache_cnt_next = dcache_cnt;

        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        icache_rdata = 128'h0;
        icache_resp  = 1'b0;
        dcache_rdata = 128'h0;
        dcache_resp  = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_next = (last_grant == PORT_I) ? GRANT_D : GRANT_I;
                end else if (req_d) begin
                    state_next = GRANT_D;
                end else if (req_i) begin
                    state_next = GRANT_I;
                end
            end

            GRANT_I: begin
                pmem_read    = 1'b1;
                pmem_address = icache_address;
                icache_rdata = pmem_rdata;
                // A response coinciding with reset is discarded, never delivered.
                icache_resp  = pmem_resp & ~rst;
                if (pmem_resp) begin
                    state_next      = RELEASE;
                    last_grant_next = PORT_I;
                    if (icache_cnt != 16'hFFFF) icache_cnt_next = icache_cnt + 16'd1;
                end
            end

            GRANT_D: begin
                pmem_write   = dcache_write;
                pmem_read    = dcache_read & ~dcache_write;
                pmem_address = dcache_address;
                pmem_wdata   = dcache_wdata;
                dcache_rdata = pmem_rdata;
                dcache_resp  = pmem_resp & ~rst;
                if (pmem_resp) begin
                    state_next      = RELEASE;
                    last_grant_next = PORT_D;
                    if (dcache_cnt != 16'hFFFF) dcache_cnt_next = dcache_cnt + 16'd1;
                end
            end

            RELEASE: begin
                // One dead cycle so the served cache can drop its request level.
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, lone grants, write priority,
// tie alternation, dropped request, counter saturation and reset during a response.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_address;
    logic [127:0] dcache_wdata;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  icache_xfers;
    logic [15:0]  dcache_xfers;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] LINE_I = 128'hDEADBEEF_01234567_89ABCDEF_00112233;
    localparam logic [127:0] LINE_W = {16{8'hA5}};
    localparam logic [127:0] LINE_D = 128'h0F0F0F0F_11112222_33334444_55556666;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .icache_xfers   (icache_xfers),
        .dcache_xfers   (dcache_xfers)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        icache_read = 1'b1; icache_address = 16'h3333;
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h4444;
        dcache_wdata = LINE_W; pmem_rdata = LINE_I; pmem_resp = 1'b0;
        tick(); tick(); settle();
        total++;
        if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=0000", {pmem_read, pmem_write, icache_resp, dcache_resp});
        end
        total++;
        if ({pmem_address, pmem_wdata, icache_rdata, dcache_rdata, icache_xfers, dcache_xfers} !== '0) begin
            bad++; $display("FAIL reset_data addr=%h wdata=%h irdata=%h drdata=%h ix=%h dx=%h exp=all zero",
                            pmem_address, pmem_wdata, icache_rdata, dcache_rdata, icache_xfers, dcache_xfers);
        end
        rst = 1'b0; settle();
        total++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            bad++; $display("FAIL reset_idle_after_release got=%b exp=00", {pmem_read, pmem_write});
        end
        tick(); settle();
        total++;
        if ({pmem_read, pmem_write, pmem_address} !== {2'b01, 16'h4444}) begin
            bad++; $display("FAIL reset_first_grant rd=%b wr=%b addr=%h exp rd=0 wr=1 addr=4444", pmem_read, pmem_write, pmem_address);
        end
        pmem_resp = 1'b1; settle();
        total++;
        if ({icache_resp, dcache_resp} !== 2'b01) begin
            bad++; $display("FAIL reset_first_resp got=%b exp=01", {icache_resp, dcache_resp});
        end
        tick();
        pmem_resp = 1'b0; icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0; settle();
        total++;
        if ({pmem_read, pmem_write, dcache_xfers, icache_xfers} !== {2'b00, 16'd1, 16'd0}) begin
            bad++; $display("FAIL reset_release strobes=%b dx=%h ix=%h exp strobes=00 dx=1 ix=0", {pmem_read, pmem_write}, dcache_xfers, icache_xfers);
        end
        tick();
    endtask

    task automatic test_lone_icache();
        icache_read = 1'b1; icache_address = 16'h1230; pmem_rdata = 128'h0; settle();
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) begin
                pmem_resp = 1'b1; pmem_rdata = LINE_I;
            end
            settle();
            total++;
            if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 16'h1230}) begin
                bad++; $display("FAIL lone_i_strobe cycle=%0d rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=1230", c, pmem_read, pmem_write, pmem_address);
            end
            total++;
            if ({icache_resp, dcache_resp} !== {(c == 5), 1'b0}) begin
                bad++; $display("FAIL lone_i_resp cycle=%0d got=%b exp=%b", c, {icache_resp, dcache_resp}, {(c == 5), 1'b0});
            end
        end
        total++;
        if (icache_rdata !== LINE_I || dcache_rdata !== 128'h0) begin
            bad++; $display("FAIL lone_i_rdata i=%h d=%h exp i=%h d=0", icache_rdata, dcache_rdata, LINE_I);
        end
        tick();
        pmem_resp = 1'b0; icache_read = 1'b0; settle();
        total++;
        if ({pmem_read, icache_resp, icache_xfers} !== {2'b00, 16'd1}) begin
            bad++; $display("FAIL lone_i_release rd=%b resp=%b ix=%h exp rd=0 resp=0 ix=1", pmem_read, icache_resp, icache_xfers);
        end
        tick();
    endtask

    task automatic test_dcache_write();
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h4000; dcache_wdata = LINE_W;
        tick(); settle();
        total++;
        if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {2'b01, 16'h4000, LINE_W}) begin
            bad++; $display("FAIL dwrite_strobe rd=%b wr=%b addr=%h wdata=%h exp rd=0 wr=1 addr=4000 wdata=%h",
                            pmem_read, pmem_write, pmem_address, pmem_wdata, LINE_W);
        end
        pmem_resp = 1'b1; pmem_rdata = LINE_D; settle();
        total++;
        if ({icache_resp, dcache_resp, icache_rdata} !== {2'b01, 128'h0}) begin
            bad++; $display("FAIL dwrite_resp iresp=%b dresp=%b irdata=%h exp iresp=0 dresp=1 irdata=0", icache_resp, dcache_resp, icache_rdata);
        end
        tick();
        pmem_resp = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0; settle();
        total++;
        if ({pmem_read, pmem_write, dcache_resp, dcache_xfers} !== {3'b000, 16'd2}) begin
            bad++; $display("FAIL dwrite_release strobes=%b resp=%b dx=%h exp strobes=00 resp=0 dx=2", {pmem_read, pmem_write}, dcache_resp, dcache_xfers);
        end
        tick(); settle();
        total++;
        if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin
            bad++; $display("FAIL dwrite_idle rd=%b wr=%b addr=%h wdata=%h exp all zero", pmem_read, pmem_write, pmem_address, pmem_wdata);
        end
    endtask

    task automatic test_contention();
        logic exp_d;
        rst = 1'b1; tick();
        rst = 1'b0;
        icache_read = 1'b1; icache_address = 16'h1111;
        dcache_read = 1'b1; dcache_write = 1'b0; dcache_address = 16'h2222;
        settle();
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2 == 0);
            for (int c = 1; c <= 3; c++) begin
                tick();
                if (c == 3) pmem_resp = 1'b1;
                settle();
                total++;
                if ({pmem_read, pmem_address} !== {1'b1, (exp_d ? 16'h2222 : 16'h1111)}) begin
                    bad++; $display("FAIL contend_grant n=%0d cycle=%0d rd=%b addr=%h exp rd=1 addr=%h",
                                    g, c, pmem_read, pmem_address, exp_d ? 16'h2222 : 16'h1111);
                end
            end
            total++;
            if ({icache_resp, dcache_resp} !== {~exp_d, exp_d}) begin
                bad++; $display("FAIL contend_resp n=%0d got=%b exp=%b", g, {icache_resp, dcache_resp}, {~exp_d, exp_d});
            end
            tick();
            pmem_resp = 1'b0; settle();
            total++;
            if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000) begin
                bad++; $display("FAIL contend_release n=%0d got=%b exp=0000", g, {pmem_read, pmem_write, icache_resp, dcache_resp});
            end
            tick(); settle();
            total++;
            if ({pmem_read, pmem_write} !== 2'b00) begin
                bad++; $display("FAIL contend_idle n=%0d got=%b exp=00", g, {pmem_read, pmem_write});
            end
        end
        icache_read = 1'b0; dcache_read = 1'b0; settle();
        total++;
        if ({icache_xfers, dcache_xfers} !== {16'd2, 16'd2}) begin
            bad++; $display("FAIL contend_counts ix=%h dx=%h exp ix=2 dx=2", icache_xfers, dcache_xfers);
        end
        tick();
    endtask

    task automatic test_drop_request();
        icache_read = 1'b1; icache_address = 16'h0ABC;
        tick(); tick();
        icache_read = 1'b0; settle();
        total++;
        if (pmem_read !== 1'b1) begin
            bad++; $display("FAIL drop_hold_c2 rd=%b exp=1", pmem_read);
        end
        tick(); settle();
        total++;
        if ({pmem_read, pmem_address} !== {1'b1, 16'h0ABC}) begin
            bad++; $display("FAIL drop_hold_c3 rd=%b addr=%h exp rd=1 addr=0abc", pmem_read, pmem_address);
        end
        tick(); pmem_resp = 1'b1; settle();
        total++;
        if ({pmem_read, icache_resp} !== 2'b11) begin
            bad++; $display("FAIL drop_resp got=%b exp=11", {pmem_read, icache_resp});
        end
        tick(); pmem_resp = 1'b0; settle();
        total++;
        if ({pmem_read, icache_resp, icache_xfers} !== {2'b00, 16'd3}) begin
            bad++; $display("FAIL drop_release rd=%b resp=%b ix=%h exp rd=0 resp=0 ix=3", pmem_read, icache_resp, icache_xfers);
        end
        tick();
    endtask

    task automatic test_saturation_and_reset();
        force dut.dcache_cnt = 16'hFFFE;
        #1;
        release dut.dcache_cnt;
        settle();
        total++;
        if (dcache_xfers !== 16'hFFFE) begin
            bad++; $display("FAIL sat_preload dx=%h exp=fffe", dcache_xfers);
        end
        for (int n = 0; n < 2; n++) begin
            dcache_read = 1'b1; dcache_address = 16'h5000;
            tick(); pmem_resp = 1'b1; settle();
            tick(); pmem_resp = 1'b0; dcache_read = 1'b0; settle();
            total++;
            if (dcache_xfers !== 16'hFFFF) begin
                bad++; $display("FAIL sat_count n=%0d dx=%h exp=ffff", n, dcache_xfers);
            end
            tick();
        end
        dcache_read = 1'b1;
        tick(); settle();
        total++;
        if (pmem_read !== 1'b1) begin
            bad++; $display("FAIL rstmid_grant rd=%b exp=1", pmem_read);
        end
        pmem_resp = 1'b1; rst = 1'b1; settle();
        total++;
        if ({icache_resp, dcache_resp} !== 2'b00) begin
            bad++; $display("FAIL rstmid_resp got=%b exp=00", {icache_resp, dcache_resp});
        end
        tick();
        rst = 1'b0; pmem_resp = 1'b0; dcache_read = 1'b0; settle();
        total++;
        if ({pmem_read, pmem_write, dcache_resp, dcache_xfers, icache_xfers} !== '0) begin
            bad++; $display("FAIL rstmid_after strobes=%b resp=%b dx=%h ix=%h exp all zero",
                            {pmem_read, pmem_write}, dcache_resp, dcache_xfers, icache_xfers);
        end
        tick(); settle();
        total++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            bad++; $display("FAIL rstmid_idle got=%b exp=00", {pmem_read, pmem_write});
        end
    endtask

    initial begin
        rst = 1'b1;
        icache_read = 1'b0; icache_address = 16'h0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = 16'h0; dcache_wdata = 128'h0;
        pmem_rdata = 128'h0; pmem_resp = 1'b0;

        test_reset();
        test_lone_icache();
        test_dcache_write();
        test_contention();
        test_drop_request();
        test_saturation_and_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single physical-memory port between the pipeline's instruction cache and data cache. Grants one whole-line transfer at a time, passes address, data and response between the winner and physical memory, and alternates priority when both caches wait. It sits between the two L1 caches and physical memory, and keeps per-port transfer counters for performance debug.

## Interface
- No parameters. Line width is fixed at 128 bits; addresses are 16 bits (lc3b_word).
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- icache_read  in  1  I-cache line read request; level held until icache_resp
- icache_address  in  16  I-cache line address
- icache_rdata  out  128  line data to the I-cache
- icache_resp  out  1  one-cycle completion pulse to the I-cache
- dcache_read  in  1  D-cache line read request
- dcache_write  in  1  D-cache line write (writeback) request
- dcache_address  in  16  D-cache line address
- dcache_wdata  in  128  D-cache writeback data
- dcache_rdata  out  128  line data to the D-cache
- dcache_resp  out  1  one-cycle completion pulse to the D-cache
- pmem_read  out  1  physical-memory read strobe
- pmem_write  out  1  physical-memory write strobe
- pmem_address  out  16  physical-memory address
- pmem_wdata  out  128  physical-memory write data
- pmem_rdata  in  128  physical-memory read data
- pmem_resp  in  1  physical-memory completion pulse
- icache_xfers  out  16  completed I-cache transfers, saturating
- dcache_xfers  out  16  completed D-cache transfers, saturating

## Operation
- The FSM has four states: IDLE, GRANT_I, GRANT_D, RELEASE. Reset enters IDLE, clears last_grant to I, and clears both counters.
- **IDLE:** nothing is granted and all pmem strobes are 0.
  - req_i = icache_read; req_d = dcache_read | dcache_write.
  - Only req_d: go to GRANT_D. Only req_i: go to GRANT_I.
  - Both requesting: grant the port that was not last_grant (alternation). After reset, dcache wins the first tie.
  - Neither requesting: stay in IDLE.
- **GRANT_I:**
  - pmem_read = 1, pmem_write = 0.
  - pmem_address = icache_address.
  - icache_rdata = pmem_rdata.
  - icache_resp = pmem_resp, passed combinationally.
- **GRANT_D:**
  - pmem_write = dcache_write.
  - pmem_read = dcache_read & ~dcache_write. If both are asserted, the write wins.
  - pmem_address = dcache_address; pmem_wdata = dcache_wdata.
  - dcache_rdata = pmem_rdata; dcache_resp = pmem_resp.
- **Leaving a GRANT state:**
  - On pmem_resp, go to RELEASE, set last_grant to the served port, and increment that port's counter.
  - A counter at 0xFFFF stays at 0xFFFF.
  - The grant is held until pmem_resp even if the requester drops its request. Physical memory always completes a started transfer.
- **RELEASE:** lasts exactly one cycle, with no strobes and no resp. It lets the served cache drop its request so a stale level cannot be re-granted. Always returns to IDLE.
- The resp and rdata of the non-granted port are always 0.
- pmem_address and pmem_wdata are 0 in IDLE and RELEASE.
- Simultaneous pmem_resp and rst: reset wins. The counter does not increment and the next state is IDLE.

## Timing
- **Reset values:**
  - All outputs are 0 (strobes, resps, rdata, address, wdata, counters).
  - The state is IDLE.
- **Grant latency:** a request sampled in IDLE at edge N produces the pmem strobe in the cycle after edge N, which is one cycle.
- **Response:** the requester's resp is in the same cycle as pmem_resp, with zero added latency.
- **Turnaround:**
  - pmem_resp in cycle k is followed by RELEASE in k+1 and IDLE in k+2.
  - The earliest next strobe is therefore k+3.
- **Reset mid-transfer:** strobes drop on the next cycle, and the in-flight response is discarded.

## Test plan
- **Reset values:** hold rst for 2 cycles with every request asserted. Required: all outputs 0 and the state IDLE; the first grant occurs one cycle after rst falls.
- **Lone I-cache read:**
  - Stimulus: icache_read at address 0x1230; memory returns 128'hDEADBEEF… after 5 cycles.
  - Required: pmem_read=1 and pmem_address=0x1230 from cycle 1.
  - Required: icache_resp pulses one cycle with matching data; dcache_resp stays 0; icache_xfers=1.
- **D-cache write with read also high:** dcache_write=dcache_read=1, address 0x4000, wdata 0xA5… Required: pmem_write=1, pmem_read=0, pmem_wdata matches; after resp, RELEASE, then IDLE.
- **Contention alternation:** hold both caches requesting continuously and respond in 3 cycles each. Required grant order after reset is D, I, D, I, and each next strobe comes 3 cycles after the previous resp.
- **Request dropped mid-grant:** deassert icache_read 2 cycles into GRANT_I. Required: pmem_read stays 1 until pmem_resp, and the arbiter then goes to RELEASE.
- **Counter saturation and reset mid-transfer:**
  - Preload dcache_xfers to 0xFFFE by forcing or by a long run, then complete two transfers. Required: 0xFFFF, 0xFFFF.
  - Assert rst in the same cycle as pmem_resp. Required: the counter is cleared and no resp is delivered.
